// File: rtl/intc_ctrl.sv
// intc_ctrl: edge-triggered interrupt controller for the single-cycle CPU.
// Latches rising edges on irq, picks the lowest-index enabled request, and
// walks the datapath through PUSH (save return PC) and VECTOR (jump to the
// handler). It then stays in SERVICE until reti.
// Optional build macro INTC_SYNC_EN: adds a two-flop synchronizer per irq bit
// ahead of edge detection, which adds 2 cycles of entry latency.
module intc_ctrl #(
  parameter int              N_IRQ    = 4,
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] VEC_BASE = 10'h3F0,
  localparam int             ID_W     = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic             ie_set,
  input  logic             ie_clr,
  input  logic             reti,
  input  logic             stack_full,
  output logic             hold,
  output logic             int_push,
  output logic             int_jump,
  output logic [PC_W-1:0]  int_vec,
  output logic [N_IRQ-1:0] irq_ack,
  output logic [ID_W-1:0]  cur_id,
  output logic             int_busy
);

  typedef enum logic [1:0] {IDLE, PUSH, VECTOR, SERVICE} state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] irq_q, irq_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic             ie_q, ie_d;
  logic [ID_W-1:0]  cur_id_q, cur_id_d;

  logic [N_IRQ-1:0] irq_src;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] clr;
  logic [ID_W-1:0]  sel;

`ifdef INTC_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync1_d;
  logic [N_IRQ-1:0] sync2_q, sync2_d;

  // Next values of the two synchronizer stages.
  always_comb begin
    sync1_d = irq;
    sync2_d = sync1_q;
  end

  // Two-flop synchronizer in front of the edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_src = sync2_q;
`else
  assign irq_src = irq;
`endif

  assign eligible = pending_q & mask_q;

  // Priority pick: lowest set index of eligible wins.
  always_comb begin
    sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel = ID_W'(i);
    end
  end

  // Next-state logic for the FSM, enable flag, mask and pending latch.
  always_comb begin
    state_d  = state_q;
    irq_d    = irq_src;
    mask_d   = mask_we ? mask_in : mask_q;
    ie_d     = ie_q;
    cur_id_d = cur_id_q;
    clr      = '0;
    case (state_q)
      IDLE: begin
        if (ie_clr)      ie_d = 1'b0;
        else if (ie_set) ie_d = 1'b1;
        // A full stack blocks entry; the request simply stays pending.
        if (ie_q && (|eligible) && !stack_full) begin
          state_d  = PUSH;
          cur_id_d = sel;
          ie_d     = 1'b0;
        end
      end
      PUSH:    state_d = VECTOR;
      VECTOR: begin
        clr[cur_id_q] = 1'b1;
        state_d       = SERVICE;
      end
      SERVICE: begin
        if (reti) begin
          state_d = IDLE;
          ie_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge in the clearing cycle is ORed in after the clear, so it survives.
    pending_d = (pending_q & ~clr) | (irq_src & ~irq_q);
  end

  // All controller state; reset aborts any entry sequence in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      irq_q     <= '0;
      mask_q    <= '0;
      ie_q      <= 1'b0;
      cur_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      mask_q    <= mask_d;
      ie_q      <= ie_d;
      cur_id_q  <= cur_id_d;
    end
  end

  // Outputs depend only on state and cur_id, never directly on inputs.
  assign hold     = (state_q == PUSH) || (state_q == VECTOR);
  assign int_push = (state_q == PUSH);
  assign int_jump = (state_q == VECTOR);
  assign int_busy = (state_q == SERVICE);
  assign cur_id   = cur_id_q;
  assign int_vec  = VEC_BASE + PC_W'({cur_id_q, 2'b00});

  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_ack
    assign irq_ack[gi] = (state_q == VECTOR) && (cur_id_q == ID_W'(gi));
  end

endmodule

// File: tb/tb_intc_ctrl.sv
// tb_intc_ctrl: directed plus randomized bench for intc_ctrl, checked each
// cycle against a behavioural model of the interrupt entry/return rules.
module tb_intc_ctrl;

  localparam int         N  = 4;
  localparam int         PW = 10;
  localparam logic [9:0] VB = 10'h3F0;
`ifdef INTC_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  irq = '0;
  logic          mask_we = 1'b0;
  logic [N-1:0]  mask_in = '0;
  logic          ie_set = 1'b0;
  logic          ie_clr = 1'b0;
  logic          reti = 1'b0;
  logic          stack_full = 1'b0;
  logic          hold, int_push, int_jump, int_busy;
  logic [PW-1:0] int_vec;
  logic [N-1:0]  irq_ack;
  logic [1:0]    cur_id;

  int n_vec  = 0;
  int n_miss = 0;

  intc_ctrl #(.N_IRQ(N), .PC_W(PW), .VEC_BASE(VB)) dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .ie_set(ie_set), .ie_clr(ie_clr), .reti(reti), .stack_full(stack_full),
    .hold(hold), .int_push(int_push), .int_jump(int_jump), .int_vec(int_vec),
    .irq_ack(irq_ack), .cur_id(cur_id), .int_busy(int_busy)
  );

  always #5 clk = ~clk;

  // Reference model. m_step counts cycles since an entry was taken:
  // 0 = waiting for a request, 1 = saving PC, 2 = jumping, 3 = in handler.
  logic [N-1:0] m_pend, m_mask, m_prev;
  logic         m_ie;
  int           m_step, m_id;
  logic [N-1:0] m_hist[$];

  task automatic model_clear();
    m_pend = '0; m_mask = '0; m_prev = '0; m_ie = 1'b0;
    m_step = 0;  m_id = 0;    m_hist.delete();
  endtask

  // Applies the inputs sampled at the edge that just occurred.
  task automatic model_update();
    logic [N-1:0] view, rise, elig;
    logic         old_ie;
    if (reset) begin
      model_clear();
      return;
    end
    m_hist.push_back(irq);
    view   = (m_hist.size() > SYNC) ? m_hist[m_hist.size() - 1 - SYNC] : '0;
    rise   = view & ~m_prev;
    m_prev = view;
    elig   = m_pend & m_mask;
    old_ie = m_ie;
    if (m_step == 0) begin
      if (ie_clr)      m_ie = 1'b0;
      else if (ie_set) m_ie = 1'b1;
      if (old_ie && elig != 0 && !stack_full) begin
        for (int i = N - 1; i >= 0; i--) if (elig[i]) m_id = i;
        m_step = 1;
        m_ie   = 1'b0;
      end
    end else if (m_step == 1) begin
      m_step = 2;
    end else if (m_step == 2) begin
      m_pend[m_id] = 1'b0;
      m_step = 3;
    end else if (reti) begin
      m_step = 0;
      m_ie   = 1'b1;
    end
    if (mask_we) m_mask = mask_in;
    m_pend = m_pend | rise;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    int e_vec;
    e_vec = (int'(VB) + 4 * m_id) % (1 << PW);
    chk({tag, ":hold"}, 32'(hold), 32'(m_step == 1 || m_step == 2));
    chk({tag, ":push"}, 32'(int_push), 32'(m_step == 1));
    chk({tag, ":jump"}, 32'(int_jump), 32'(m_step == 2));
    chk({tag, ":busy"}, 32'(int_busy), 32'(m_step == 3));
    chk({tag, ":vec"},  32'(int_vec), 32'(e_vec));
    chk({tag, ":ack"},  32'(irq_ack), (m_step == 2) ? (32'd1 << m_id) : 32'd0);
    chk({tag, ":id"},   32'(cur_id), 32'(m_id));
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run(int n, string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic pulse_irq(logic [N-1:0] bits, string tag);
    irq = bits;
    cycle(tag);
    irq = '0;
  endtask

  task automatic set_mask(logic [N-1:0] m, string tag);
    mask_we = 1'b1; mask_in = m;
    cycle(tag);
    mask_we = 1'b0;
  endtask

  task automatic do_reti(string tag);
    reti = 1'b1;
    cycle(tag);
    reti = 1'b0;
  endtask

  // Bounded wait for the handler to start.
  task automatic wait_busy(string tag);
    int k = 0;
    while (int_busy !== 1'b1 && k < 12) begin cycle(tag); k++; end
    chk({tag, ":busy_wait"}, 32'(int_busy), 32'd1);
  endtask

  // Bounded wait for the PUSH cycle.
  task automatic wait_push(string tag);
    int k = 0;
    while (int_push !== 1'b1 && k < 12) begin cycle(tag); k++; end
    chk({tag, ":push_wait"}, 32'(int_push), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    @(negedge clk);
    check_all("reset");
    chk("reset_vec", 32'(int_vec), 32'h3F0);
    cycle("reset");
    reset = 1'b0;
    run(2, "idle");

    // Single request on irq[2].
    mask_we = 1'b1; mask_in = 4'b0100; ie_set = 1'b1;
    cycle("single_cfg");
    mask_we = 1'b0; ie_set = 1'b0;
    pulse_irq(4'b0100, "single_irq");
    wait_push("single");
    cycle("single_vec");
    chk("single_vec_addr", 32'(int_vec), 32'h3F8);
    chk("single_ack", 32'(irq_ack), 32'h4);
    cycle("single_svc");
    chk("single_busy", 32'(int_busy), 32'd1);
    run(2, "single_svc");
    do_reti("single_reti");
    chk("single_idle", 32'(int_busy), 32'd0);

    // Priority between irq[3] and irq[1] rising together.
    set_mask(4'b1111, "prio_mask");
    pulse_irq(4'b1010, "prio_irq");
    wait_busy("prio_first");
    chk("prio_id", 32'(cur_id), 32'd1);
    chk("prio_vec", 32'(int_vec), 32'h3F4);
    do_reti("prio_reti");
    wait_busy("prio_second");
    chk("prio_vec3", 32'(int_vec), 32'h3FC);
    do_reti("prio_reti2");

    // Masked request, then blocked by a full stack.
    set_mask(4'b0000, "mask_off");
    pulse_irq(4'b0001, "mask_irq");
    run(4, "masked");
    chk("masked_hold", 32'(hold), 32'd0);
    stack_full = 1'b1;
    set_mask(4'b0001, "mask_on");
    run(4, "stack_full");
    chk("full_hold", 32'(hold), 32'd0);
    stack_full = 1'b0;
    cycle("stack_free");
    chk("free_push", 32'(int_push), 32'd1);
    run(3, "free_svc");
    do_reti("free_reti");

    // No nesting: irq[0] arrives while irq[2] is being serviced.
    set_mask(4'b0101, "nest_mask");
    pulse_irq(4'b0100, "nest_irq2");
    wait_busy("nest_svc2");
    pulse_irq(4'b0001, "nest_irq0");
    run(4, "nest_hold");
    chk("nest_busy", 32'(int_busy), 32'd1);
    chk("nest_id", 32'(cur_id), 32'd2);
    do_reti("nest_reti");
    cycle("nest_reentry");
    chk("nest_push", 32'(int_push), 32'd1);
    chk("nest_id0", 32'(cur_id), 32'd0);
    run(3, "nest_svc0");
    do_reti("nest_reti0");

    // ie_set and ie_clr together: clear wins.
    ie_set = 1'b1; ie_clr = 1'b1;
    cycle("ie_both");
    ie_set = 1'b0; ie_clr = 1'b0;
    pulse_irq(4'b0001, "ie_irq");
    run(6, "ie_off");
    chk("ie_off_hold", 32'(hold), 32'd0);
    ie_set = 1'b1;
    cycle("ie_on");
    ie_set = 1'b0;
    wait_busy("ie_svc");
    do_reti("ie_reti");

    // A new edge on cur_id during VECTOR keeps that bit pending.
    set_mask(4'b0111, "vec_mask");
    pulse_irq(4'b0010, "vec_irq");
    begin
      int k = 0;
      while (int_jump !== 1'b1 && k < 12) begin cycle("vec_wait"); k++; end
      chk("vec_jump_wait", 32'(int_jump), 32'd1);
    end
    pulse_irq(4'b0010, "vec_reedge");
    run(2, "vec_svc");
    do_reti("vec_reti");
    wait_busy("vec_again");
    chk("vec_again_id", 32'(cur_id), 32'd1);
    do_reti("vec_reti2");

    // Asynchronous reset in the middle of PUSH.
    pulse_irq(4'b0100, "rst_irq");
    wait_push("rst");
    reset = 1'b1;
    #1;
    model_clear();
    check_all("rst_async");
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_vec", 32'(int_vec), 32'h3F0);
    cycle("rst_held");
    reset = 1'b0;
    run(5, "rst_after");
    chk("rst_nopush", 32'(int_push), 32'd0);

    // Randomized traffic.
    mask_we = 1'b1; mask_in = 4'b1111; ie_set = 1'b1;
    cycle("rand_cfg");
    for (int i = 0; i < 500; i++) begin
      irq        = N'($urandom);
      mask_we    = ($urandom_range(0, 7) == 0);
      mask_in    = N'($urandom);
      ie_set     = ($urandom_range(0, 3) == 0);
      ie_clr     = ($urandom_range(0, 15) == 0);
      reti       = ($urandom_range(0, 2) == 0);
      stack_full = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end
    irq = '0; mask_we = 1'b0; ie_set = 1'b0; ie_clr = 1'b0;
    reti = 1'b0; stack_full = 1'b0;
    run(3, "rand_tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
